// File: rtl/uart_pkg.sv
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions (state encoding, default bit period)
//               used by uart_rx and uart_tx.
//               Optional feature macro: UART_RX_PARITY_EN (adds PARITY state).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  // Default number of clk cycles per serial bit.
  localparam int CLKS_PER_BIT_DEF = 16;

  // Receiver state encoding; PARITY exists only when parity is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY    = 3'd3,
`endif
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } uart_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_rx_if.sv
// ============================================================================
// Module      : uart_rx_if
// Description : Receive-side result bundle of the UART receiver.
//               master = receiver (drives), slave = consumer (observes).
//               Optional feature macro: UART_RX_PARITY_EN (adds o_parity_err).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_rx_if;

  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;
`ifdef UART_RX_PARITY_EN
  logic       o_parity_err;
`endif

  modport master (
`ifdef UART_RX_PARITY_EN
    output o_parity_err,
`endif
    output o_data,
    output o_valid,
    output o_frame_err,
    output o_busy
  );

  modport slave (
`ifdef UART_RX_PARITY_EN
    input o_parity_err,
`endif
    input o_data,
    input o_valid,
    input o_frame_err,
    input o_busy
  );

endinterface

`default_nettype wire

// File: rtl/uart_sync2.sv
// ============================================================================
// Module      : uart_sync2
// Description : Two-flop synchronizer for a single asynchronous input bit,
//               with a parameterized reset value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops settle metastability before the value is used.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : UART receiver, 8 data bits LSB first, one stop bit, mid-bit
//               sampling with start-bit glitch rejection and break handling.
//               Optional feature macro: UART_RX_PARITY_EN (8E1 with parity
//               error reporting); undefined gives 8N1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_rx,
  uart_rx_if.master rx_if
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  logic          rx_s;
  uart_state_e   state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  // Stop-bit verdicts are staged one cycle before they reach the outputs.
  logic          good_pend_q, good_pend_d;
  logic          ferr_pend_q, ferr_pend_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          perr_pend_q, perr_pend_d;
  logic          perr_q, perr_d;
`endif

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (i_rx),
    .q     (rx_s)
  );

  // Next-state, counter, shift register and output-pulse logic.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q + 1'b1;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    good_pend_d = 1'b0;
    ferr_pend_d = 1'b0;
    valid_d     = good_pend_q;
    ferr_d      = ferr_pend_q;
    data_d      = good_pend_q ? shift_q : data_q;
`ifdef UART_RX_PARITY_EN
    par_d       = par_q;
    perr_pend_d = 1'b0;
    perr_d      = perr_pend_q;
`endif

    case (state_q)
      ST_IDLE: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (!rx_s) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (clk_cnt_q == HALF_M1) begin
          clk_cnt_d = '0;
          // A line already back high at mid start bit was a glitch.
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          par_d     = rx_s;
          state_d   = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (clk_cnt_q == FULL_M1) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to zero.
            if (^{shift_q, par_q}) begin
              perr_pend_d = 1'b1;
            end else begin
              good_pend_d = 1'b1;
            end
`else
            good_pend_d = 1'b1;
`endif
          end else begin
            ferr_pend_d = 1'b1;
            state_d     = ST_WAIT_IDLE;
          end
        end
      end

      ST_WAIT_IDLE: begin
        // Hold off through a break so it yields a single frame error.
        clk_cnt_d = '0;
        if (rx_s) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        clk_cnt_d = '0;
        state_d   = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      data_q      <= 8'h00;
      good_pend_q <= 1'b0;
      ferr_pend_q <= 1'b0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q       <= 1'b0;
      perr_pend_q <= 1'b0;
      perr_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      good_pend_q <= good_pend_d;
      ferr_pend_q <= ferr_pend_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
`ifdef UART_RX_PARITY_EN
      par_q       <= par_d;
      perr_pend_q <= perr_pend_d;
      perr_q      <= perr_d;
`endif
    end
  end

  assign rx_if.o_data      = data_q;
  assign rx_if.o_valid     = valid_q;
  assign rx_if.o_frame_err = ferr_q;
  assign rx_if.o_busy      = (state_q != ST_IDLE);
`ifdef UART_RX_PARITY_EN
  assign rx_if.o_parity_err = perr_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Scoreboard testbench for uart_rx at CLKS_PER_BIT = 16.
//               Optional feature macro: UART_RX_PARITY_EN (parity frames).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  // Clocks from the edge first sampling the start bit to o_valid rising.
  localparam int LAT = 2 + CPB / 2 + 9 * CPB + 1 + PBITS * CPB;

  localparam int K_NONE  = -1;
  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    bit         chk_data;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_rx  = 1'b1;
  int         cyc   = 0;
  int         tests = 0;
  int         fails = 0;
  logic [7:0] last_good = 8'h00;
  logic       perr;

  uart_rx_if rx_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i_rx  (i_rx),
    .rx_if (rx_if)
  );

`ifdef UART_RX_PARITY_EN
  assign perr = rx_if.o_parity_err;
`else
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  // Cycle index: value after the Nth rising edge is N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one frame starting at a falling clock edge; queue its expected result.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input bit par_flip, input int kind);
    exp_t e;
    if (kind != K_NONE) begin
      e.kind     = kind;
      e.chk_data = (kind != K_PERR);
      e.data     = (kind == K_VALID) ? d : last_good;
      e.cyc      = (kind == K_FERR) ? -1 : cyc + 1 + LAT;
      if (kind == K_PERR) e.cyc = -1;
      exp_q.push_back(e);
      if (kind == K_VALID) last_good = d;
    end
    i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      i_rx = d[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    i_rx = (^d) ^ par_flip;
    repeat (CPB) @(negedge clk);
`endif
    i_rx = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  // Monitor: every output pulse is popped against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   act_kind;
    if (rst_n && (rx_if.o_valid || rx_if.o_frame_err || perr)) begin
      act_kind = rx_if.o_valid ? K_VALID : (rx_if.o_frame_err ? K_FERR : K_PERR);
      check("pulse_exclusive", 32'($countones({rx_if.o_valid, rx_if.o_frame_err, perr})), 32'd1);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got kind %0d data %0h, expected no pulse (cycle %0d)",
                 act_kind, rx_if.o_data, cyc);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", act_kind, e.kind);
        if (e.chk_data) check("o_data", {24'd0, rx_if.o_data}, {24'd0, e.data});
        if (e.cyc >= 0) check("latency_cycle", cyc, e.cyc);
      end
    end
  end

  // Stimulus sequence.
  initial begin
    bit cleared;
    rst_n = 1'b0;
    i_rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_o_data", {24'd0, rx_if.o_data}, 32'h00);
    check("reset_o_valid", rx_if.o_valid, 1'b0);
    check("reset_o_frame_err", rx_if.o_frame_err, 1'b0);
    check("reset_o_busy", rx_if.o_busy, 1'b0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Plain good frame.
    send_frame(8'h55, 1'b1, 1'b0, K_VALID);
    i_rx = 1'b1;
    repeat (20) @(negedge clk);

    // Bad stop bit followed by a 500-clock break, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0, K_FERR);
    repeat (500) @(negedge clk);
    i_rx = 1'b1;
    repeat (40) @(negedge clk);
    send_frame(8'h81, 1'b1, 1'b0, K_VALID);
    i_rx = 1'b1;
    repeat (20) @(negedge clk);

    // Asynchronous reset in the middle of data bit 4 of 0xFF.
    fork
      send_frame(8'hFF, 1'b1, 1'b0, K_NONE);
      begin
        repeat (CPB + 4 * CPB + CPB / 2) @(negedge clk);
        check("busy_midframe", rx_if.o_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_o_data", {24'd0, rx_if.o_data}, 32'h00);
        check("midreset_o_busy", rx_if.o_busy, 1'b0);
        check("midreset_o_valid", rx_if.o_valid, 1'b0);
        last_good = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
      end
    join
    i_rx = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h12, 1'b1, 1'b0, K_VALID);
    i_rx = 1'b1;
    repeat (20) @(negedge clk);

    // Back-to-back frames: second start bit directly after the stop bit.
    send_frame(8'hA3, 1'b1, 1'b0, K_VALID);
    send_frame(8'h00, 1'b1, 1'b0, K_VALID);
    i_rx = 1'b1;
    repeat (20) @(negedge clk);

    // Five-clock low glitch must be rejected without any pulse.
    i_rx = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy_high", rx_if.o_busy, 1'b1);
    i_rx = 1'b1;
    cleared = 1'b0;
    for (int i = 0; i < 12 && !cleared; i++) begin
      @(negedge clk);
      if (!rx_if.o_busy) cleared = 1'b1;
    end
    check("glitch_busy_cleared", cleared, 1'b1);
    repeat (30) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: parity bit 0 is wrong, parity bit 1 is right.
    send_frame(8'h07, 1'b1, 1'b1, K_PERR);
    i_rx = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h07, 1'b1, 1'b0, K_VALID);
    i_rx = 1'b1;
    repeat (20) @(negedge clk);
`endif

    // Wait (bounded) for all expected pulses to be consumed.
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
    $fatal(1);
  end

endmodule

`default_nettype wire
